branch_tag_freelist: RTL and testbench

Allocates branch checkpoint tags to the dispatch group leaving the instruction buffer, in the rename stage directly downstream of it. Each cycle the group is accepted, it hands one unique tag to every branch slot in the DISPATCH_WIDTH-wide group. It tells rename to stall when free tags are too few, and recycles tags released by branch resolution. The free list is a circular FIFO of tag IDs with head and tail pointers and a free counter.

---
 rtl/branch_tag_freelist.sv | 77 +++++++
 tb/tb_branch_tag_freelist.sv | 132 +++++++++++++
 2 files changed

// File: rtl/branch_tag_freelist.sv
// branch_tag_freelist: circular free list handing unique branch checkpoint tags to a dispatch group
module branch_tag_freelist #(
  parameter int NUM_TAGS       = 8,
  parameter int TAG_LOG        = 3,
  parameter int DISPATCH_WIDTH = 4,
  parameter int COUNT_W        = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush_i,
  input  logic                              instBufferReady_i,
  input  logic                              stall_i,
  input  logic [COUNT_W-1:0]                branchCount_i,
  input  logic [DISPATCH_WIDTH-1:0]         branchVector_i,
  input  logic                              releaseValid_i,
  input  logic [TAG_LOG-1:0]                releaseTag_i,
  output logic [DISPATCH_WIDTH*TAG_LOG-1:0] tags_o,
  output logic [DISPATCH_WIDTH-1:0]         tagValid_o,
  output logic                              stallBranch_o,
  output logic [TAG_LOG:0]                  freeCount_o,
  output logic                              overflow_o
);
  localparam int FW = TAG_LOG + 1;
  localparam int CW = TAG_LOG + COUNT_W;
  logic [TAG_LOG-1:0] entries_q [NUM_TAGS];
  logic [TAG_LOG-1:0] entries_d [NUM_TAGS];
  logic [TAG_LOG-1:0] head_q, head_d, tail_q, tail_d, r;
  logic [FW-1:0]      free_cnt_q, free_cnt_d, alloc;
  logic               overflow_q, overflow_d, fire, room, rel_ok;
  // Stall/fire decision, per-slot tag selection by branch rank, and next-state of the free list
  always_comb begin
    stallBranch_o = ~reset & instBufferReady_i & (CW'(branchCount_i) > CW'(free_cnt_q));
    fire = ~reset & instBufferReady_i & ~stall_i & ~stallBranch_o;
    alloc = fire ? FW'(branchCount_i) : '0;
    room = (free_cnt_q - alloc) != FW'(NUM_TAGS);
    rel_ok = releaseValid_i & room;
    tags_o = '0;
    tagValid_o = '0;
    r = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      tags_o[k*TAG_LOG +: TAG_LOG] = (fire & branchVector_i[k]) ? entries_q[head_q + r] : '0;
      tagValid_o[k] = fire & branchVector_i[k];
      r = r + TAG_LOG'(branchVector_i[k]);
    end
    entries_d = entries_q;
    if (rel_ok) entries_d[tail_q] = releaseTag_i;
    head_d = head_q + (fire ? TAG_LOG'(branchCount_i) : '0);
    tail_d = tail_q + TAG_LOG'(rel_ok);
    free_cnt_d = free_cnt_q - alloc + FW'(rel_ok);
    overflow_d = releaseValid_i & ~room;
    if (flush_i) begin
      for (int i = 0; i < NUM_TAGS; i++) entries_d[i] = TAG_LOG'(i);
      head_d = '0;
      tail_d = '0;
      free_cnt_d = FW'(NUM_TAGS);
      overflow_d = 1'b0;
    end
  end
  // State registers; reset restores the identity free list with every tag free
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) entries_q[i] <= TAG_LOG'(i);
      head_q <= '0;
      tail_q <= '0;
      free_cnt_q <= FW'(NUM_TAGS);
      overflow_q <= 1'b0;
    end else begin
      entries_q <= entries_d;
      head_q <= head_d;
      tail_q <= tail_d;
      free_cnt_q <= free_cnt_d;
      overflow_q <= overflow_d;
    end
  end
  assign freeCount_o = free_cnt_q;
  assign overflow_o = overflow_q;
endmodule

// File: tb/tb_branch_tag_freelist.sv
// tb_branch_tag_freelist: directed scoreboard bench for the branch tag free list
module tb_branch_tag_freelist;
  logic        clk = 0, reset = 0, flush_i = 0, instBufferReady_i = 0, stall_i = 0;
  logic [2:0]  branchCount_i = 0;
  logic [3:0]  branchVector_i = 0;
  logic        releaseValid_i = 0;
  logic [2:0]  releaseTag_i = 0;
  logic [11:0] tags_o;
  logic [3:0]  tagValid_o;
  logic        stallBranch_o, overflow_o;
  logic [3:0]  freeCount_o;
  int          cyc = 0, checks = 0, errors = 0;
  typedef struct {
    string       nm;
    int          cyc;
    bit          late;
    logic [11:0] tags;
    logic [3:0]  valid;
    logic        stall;
    logic [3:0]  fc;
    logic        ov;
  } exp_t;
  exp_t q[$];
  int   fq[$], oq[$];

  branch_tag_freelist dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .instBufferReady_i(instBufferReady_i),
    .stall_i(stall_i), .branchCount_i(branchCount_i), .branchVector_i(branchVector_i),
    .releaseValid_i(releaseValid_i), .releaseTag_i(releaseTag_i), .tags_o(tags_o),
    .tagValid_o(tagValid_o), .stallBranch_o(stallBranch_o), .freeCount_o(freeCount_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit late);
    exp_t e;
    if (q.size() != 0 && q[0].cyc == cyc && q[0].late == late) begin
      e = q.pop_front();
      checks++;
      if (tags_o !== e.tags || tagValid_o !== e.valid || stallBranch_o !== e.stall ||
          freeCount_o !== e.fc || overflow_o !== e.ov) begin
        errors++;
        $display("FAIL %s: got tags=%h valid=%b stall=%b fc=%0d ov=%b, expected tags=%h valid=%b stall=%b fc=%0d ov=%b",
                 e.nm, tags_o, tagValid_o, stallBranch_o, freeCount_o, overflow_o,
                 e.tags, e.valid, e.stall, e.fc, e.ov);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    check(1'b0);
    #3;
    check(1'b1);
  end

  task automatic step(input string nm, input logic rdy, st, fl, input logic [3:0] bv,
                      input logic rv, input logic [2:0] rt, input logic [11:0] et,
                      input logic [3:0] ev, input logic es, input logic [3:0] efc, input logic eov);
    @(posedge clk);
    #1;
    instBufferReady_i = rdy;
    stall_i = st;
    flush_i = fl;
    branchVector_i = bv;
    branchCount_i = 3'($countones(bv));
    releaseValid_i = rv;
    releaseTag_i = rt;
    q.push_back('{nm, cyc, 1'b0, et, ev, es, efc, eov});
  endtask

  initial begin
    logic [11:0] et;
    int rel;
    #2 reset = 1;
    step("in_reset",     1, 0, 0, 4'b1010, 0, 0, 12'h000, 4'b0000, 0, 8, 0);
    @(posedge clk); #1 reset = 0; instBufferReady_i = 0;
    step("alloc_1010",   1, 0, 0, 4'b1010, 0, 0, 12'h200, 4'b1010, 0, 8, 0);
    step("flush_a",      0, 0, 1, 4'b0000, 0, 0, 12'h000, 4'b0000, 0, 6, 0);
    step("alloc4_a",     1, 0, 0, 4'b1111, 0, 0, 12'h688, 4'b1111, 0, 8, 0);
    step("alloc4_b",     1, 0, 0, 4'b1111, 0, 0, 12'hFAC, 4'b1111, 0, 4, 0);
    step("empty_stall",  1, 0, 0, 4'b0001, 1, 5, 12'h000, 4'b0000, 1, 0, 0);
    step("reuse_tag5",   1, 0, 0, 4'b0001, 0, 0, 12'h005, 4'b0001, 0, 1, 0);
    step("zero_br_empty",1, 0, 0, 4'b0000, 0, 0, 12'h000, 4'b0000, 0, 0, 0);
    step("rel_1",        0, 0, 0, 4'b0000, 1, 1, 12'h000, 4'b0000, 0, 0, 0);
    step("rel_2",        0, 0, 0, 4'b0000, 1, 2, 12'h000, 4'b0000, 0, 1, 0);
    step("alloc_and_rel",1, 0, 0, 4'b0011, 1, 3, 12'h011, 4'b0011, 0, 2, 0);
    step("tag3_next",    1, 0, 0, 4'b0001, 0, 0, 12'h003, 4'b0001, 0, 1, 0);
    step("idle_empty",   0, 0, 0, 4'b0000, 0, 0, 12'h000, 4'b0000, 0, 0, 0);
    step("flush_b",      0, 0, 1, 4'b0000, 0, 0, 12'h000, 4'b0000, 0, 0, 0);
    step("rel_when_full",0, 0, 0, 4'b0000, 1, 2, 12'h000, 4'b0000, 0, 8, 0);
    step("overflow_hi",  0, 0, 0, 4'b0000, 0, 0, 12'h000, 4'b0000, 0, 8, 1);
    step("overflow_lo",  0, 0, 0, 4'b0000, 0, 0, 12'h000, 4'b0000, 0, 8, 0);
    step("alloc3",       1, 0, 0, 4'b0111, 0, 0, 12'h088, 4'b0111, 0, 8, 0);
    step("flush_c",      0, 0, 1, 4'b0000, 1, 7, 12'h000, 4'b0000, 0, 5, 0);
    step("post_flush",   1, 0, 0, 4'b0011, 0, 0, 12'h008, 4'b0011, 0, 8, 0);
    step("backend_stall",1, 1, 0, 4'b0011, 0, 0, 12'h000, 4'b0000, 0, 6, 0);
    step("flush_d",      0, 0, 1, 4'b0000, 0, 0, 12'h000, 4'b0000, 0, 6, 0);
    for (int i = 0; i < 8; i++) fq.push_back(i);
    for (int rd = 0; rd < 20; rd++) begin
      rel = (oq.size() != 0) ? oq.pop_front() : -1;
      et = '0;
      et[2:0] = 3'(fq[0]);
      et[8:6] = 3'(fq[1]);
      step($sformatf("wrap_a%0d", rd), 1, 0, 0, 4'b0101, rel >= 0, 3'(rel), et, 4'b0101, 0, 4'(fq.size()), 0);
      oq.push_back(fq.pop_front());
      oq.push_back(fq.pop_front());
      if (rel >= 0) fq.push_back(rel);
      rel = oq.pop_front();
      step($sformatf("wrap_b%0d", rd), 0, 0, 0, 4'b0000, 1, 3'(rel), 12'h000, 4'b0000, 0, 4'(fq.size()), 0);
      fq.push_back(rel);
    end
    et = '0;
    et[2:0] = 3'(fq[0]);
    et[5:3] = 3'(fq[1]);
    step("pre_async_rst", 1, 0, 0, 4'b0011, 0, 0, et, 4'b0011, 0, 4'(fq.size()), 0);
    q.push_back('{"async_rst", cyc, 1'b1, 12'h000, 4'b0000, 1'b0, 4'd8, 1'b0});
    @(negedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0; instBufferReady_i = 0;
    step("post_rst",     1, 0, 0, 4'b0001, 0, 0, 12'h000, 4'b0001, 0, 8, 0);
    step("idle_end",     0, 0, 0, 4'b0000, 0, 0, 12'h000, 4'b0000, 0, 7, 0);
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations unchecked, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
